counter_stream_receiver: RTL and testbench
==========================================

Name: counter_stream_receiver

Overview:
- Receive end of the two-lane serial counter stream.
- Deserialises lane A and lane B bit streams, MSB first, framed by a one-cycle `latch` strobe, into parallel words.
- Checks that lane A decrements by 1 and lane B increments by 1 (mod 2^WIDTH) between consecutive words.
- Sits between the counter-stream pins and the status/debug logic; exports words, per-word error pulses and error statistics.

Parameters:
- WIDTH, 8, bits per word on each lane.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- latch  input  1  frame strobe; high on the cycle the MSB of a new word is on in_a/in_b.
- in_a  input  1  lane A serial data.
- in_b  input  1  lane B serial data.
- word_valid  output  1  one-cycle pulse; word_a/word_b hold a complete word.
- word_a  output  WIDTH  last complete lane A word.
- word_b  output  WIDTH  last complete lane B word.
- err_a  output  1  pulse with word_valid; lane A sequence mismatch.
- err_b  output  1  pulse with word_valid; lane B sequence mismatch.
- frame_err  output  1  one-cycle pulse; latch seen mid-word.
- err_sticky  output  1  set on any err_a/err_b/frame_err; cleared only by reset.
- err_count  output  ERR_CNT_W  saturating count of words with err_a|err_b, plus frame errors.

Behaviour:
- Reset (asserted low, async) clears:
  - outputs: all to 0 (word_a, word_b, err_count = 0; all flags 0).
  - internal state: state=IDLE, bit counter=0, seeded=0.
- States: IDLE, SHIFT.
- IDLE:
  - in_a/in_b ignored while latch=0.
  - latch=1: capture bit WIDTH-1 of both lanes, bit counter=1, go to SHIFT.
- SHIFT, latch=0:
  - Shift in next bit; counter++.
  - When counter reaches WIDTH, the word is complete: on the next clock word_valid=1, word_a/word_b updated, return to IDLE.
  - Latency: word_valid is high exactly 1 cycle after the LSB sample.
- SHIFT, latch=1 (mid-word):
  - Discard the partial word; frame_err=1 next cycle.
  - seeded cleared.
  - The current bit is captured as the MSB of a new word (counter=1, stay in SHIFT).
- Back-to-back: latch high on the cycle immediately after the LSB is legal.
  - Starts the next word from IDLE with no gap.
  - No frame_err.
- Sequence check on each completed word:
  - seeded=0: no check, err_a=err_b=0; store words as reference; seeded=1.
  - seeded=1: err_a = (word_a != prev_a - 1 mod 2^WIDTH); err_b = (word_b != prev_b + 1 mod 2^WIDTH).
  - Reference is always updated with the received words, so a single corrupt word flags twice (entry and exit); this is intended.
- Wrap-around is legal and not an error: 0x00→0xFF on A, 0xFF→0x00 on B.
- err_count:
  - Increments by 1 per completed word with (err_a|err_b).
  - Increments by 1 per frame_err.
  - Simultaneous increment sources in one cycle add 1 only.
  - Saturates at 2^ERR_CNT_W-1.
- Reset mid-word: partial word lost, no word_valid, no error.

Optional Feature:
- Macro: COUNTER_RX_CHECK_EN.
- Defined: sequence checking, err_a, err_b, err_sticky and err_count as above.
- Undefined:
  - Pure deserialiser.
  - err_a, err_b, err_sticky and err_count tied to 0; no reference registers.
  - frame_err still generated.

Test Plan:
- Reset then frames A=0xFF,B=0x81 then A=0xFE,B=0x82 → word_valid twice, words match, err_a=err_b=0, err_count=0.
- Wrap: A=0x00,B=0xFF then A=0xFF,B=0x00 → no errors.
- Corrupt: A 0x10,0x0F,0x0E sent as 0x10,0x2F,0x0E → err_a on words 2 and 3, err_count=2, err_sticky=1, err_b=0.
- Latch asserted at bit 4 of a word → frame_err pulse; no word_valid for the partial word; next word valid after 8 bits; that word unchecked (seeded cleared).
- Back-to-back frames with no idle cycle, 300 words, one error injected every word → err_count saturates at 255.
- Async reset (reset low) asserted mid-word at bit 5 → all outputs 0 immediately; first word after release is unchecked, errors 0.

Source files
------------

// File: rtl/counter_stream_receiver.sv
// counter_stream_receiver
//   Receive end of the two-lane serial counter stream. Deserialises lane A and
//   lane B (MSB first, framed by a one-cycle latch strobe) into parallel words
//   and, when COUNTER_RX_CHECK_EN is defined, checks that lane A counts down and
//   lane B counts up by one between consecutive words.
//
//   Optional feature macro: COUNTER_RX_CHECK_EN
//     defined   : sequence checking, err_a/err_b, err_sticky and err_count live.
//     undefined : pure deserialiser; err_a/err_b/err_sticky/err_count tied to 0.
//                 frame_err is generated in both builds.
//
// Ports
//   clock       in   system clock, rising edge
//   reset       in   asynchronous active-low reset
//   latch       in   frame strobe, high with the MSB of a new word
//   in_a, in_b  in   lane A / lane B serial data
//   word_valid  out  one-cycle pulse, word_a/word_b hold a complete word
//   word_a/b    out  last complete lane A / lane B word
//   err_a/b     out  sequence mismatch pulses, aligned with word_valid
//   frame_err   out  one-cycle pulse, latch seen mid-word
//   err_sticky  out  set by any error, cleared only by reset
//   err_count   out  saturating count of errored words plus frame errors
module counter_stream_receiver #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 latch,
  input  logic                 in_a,
  input  logic                 in_b,
  output logic                 word_valid,
  output logic [WIDTH-1:0]     word_a,
  output logic [WIDTH-1:0]     word_b,
  output logic                 err_a,
  output logic                 err_b,
  output logic                 frame_err,
  output logic                 err_sticky,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sh_a_q, sh_a_d;
  logic [WIDTH-1:0]   sh_b_q, sh_b_d;
  logic               valid_q, valid_d;
  logic [WIDTH-1:0]   word_a_q, word_a_d;
  logic [WIDTH-1:0]   word_b_q, word_b_d;
  logic               frame_err_q, frame_err_d;

  // Shift registers with the current lane bits appended as the new LSB.
  logic [WIDTH-1:0]   nxt_a_c, nxt_b_c;
  assign nxt_a_c = {sh_a_q[WIDTH-2:0], in_a};
  assign nxt_b_c = {sh_b_q[WIDTH-2:0], in_b};

  // Framing FSM state and data registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sh_a_q      <= '0;
      sh_b_q      <= '0;
      valid_q     <= 1'b0;
      word_a_q    <= '0;
      word_b_q    <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_a_q      <= sh_a_d;
      sh_b_q      <= sh_b_d;
      valid_q     <= valid_d;
      word_a_q    <= word_a_d;
      word_b_q    <= word_b_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Framing FSM next state and registered outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_a_d      = sh_a_q;
    sh_b_d      = sh_b_q;
    valid_d     = 1'b0;
    word_a_d    = word_a_q;
    word_b_d    = word_b_q;
    frame_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (latch) begin
          sh_a_d  = WIDTH'(in_a);
          sh_b_d  = WIDTH'(in_b);
          cnt_d   = CNT_W'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (latch) begin
          // Restart: the partial word is dropped and this bit is the new MSB.
          frame_err_d = 1'b1;
          sh_a_d      = WIDTH'(in_a);
          sh_b_d      = WIDTH'(in_b);
          cnt_d       = CNT_W'(1);
        end else begin
          sh_a_d = nxt_a_c;
          sh_b_d = nxt_b_c;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            // LSB sampled: publish the word and go back to waiting for latch.
            valid_d  = 1'b1;
            word_a_d = nxt_a_c;
            word_b_d = nxt_b_c;
            cnt_d    = '0;
            state_d  = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign word_valid = valid_q;
  assign word_a     = word_a_q;
  assign word_b     = word_b_q;
  assign frame_err  = frame_err_q;

`ifdef COUNTER_RX_CHECK_EN
  logic [WIDTH-1:0]     prev_a_q, prev_a_d;
  logic [WIDTH-1:0]     prev_b_q, prev_b_d;
  logic                 seeded_q, seeded_d;
  logic                 err_a_q, err_a_d;
  logic                 err_b_q, err_b_d;
  logic                 sticky_q, sticky_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Sequence checker state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_a_q  <= '0;
      prev_b_q  <= '0;
      seeded_q  <= 1'b0;
      err_a_q   <= 1'b0;
      err_b_q   <= 1'b0;
      sticky_q  <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      prev_a_q  <= prev_a_d;
      prev_b_q  <= prev_b_d;
      seeded_q  <= seeded_d;
      err_a_q   <= err_a_d;
      err_b_q   <= err_b_d;
      sticky_q  <= sticky_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Compare each completed word with the previous one; the reference always
  // follows the received data, so a single bad word flags on entry and exit.
  always_comb begin
    prev_a_d  = prev_a_q;
    prev_b_d  = prev_b_q;
    seeded_d  = seeded_q;
    err_a_d   = 1'b0;
    err_b_d   = 1'b0;
    sticky_d  = sticky_q;
    err_cnt_d = err_cnt_q;
    if (valid_d) begin
      if (seeded_q) begin
        err_a_d = (word_a_d != (prev_a_q - WIDTH'(1)));
        err_b_d = (word_b_d != (prev_b_q + WIDTH'(1)));
      end
      prev_a_d = word_a_d;
      prev_b_d = word_b_d;
      seeded_d = 1'b1;
    end
    if (frame_err_d) begin
      seeded_d = 1'b0;
    end
    // Word errors and frame errors never coincide; either adds one.
    if (err_a_d || err_b_d || frame_err_d) begin
      sticky_d = 1'b1;
      if (err_cnt_q != {ERR_CNT_W{1'b1}}) begin
        err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end
    end
  end

  assign err_a      = err_a_q;
  assign err_b      = err_b_q;
  assign err_sticky = sticky_q;
  assign err_count  = err_cnt_q;
`else
  assign err_a      = 1'b0;
  assign err_b      = 1'b0;
  assign err_sticky = 1'b0;
  assign err_count  = '0;
`endif

endmodule

// File: tb/tb_counter_stream_receiver.sv
// Testbench for counter_stream_receiver: frame-level reference model plus
// literal expectations for the directed scenarios.
module tb_counter_stream_receiver;

  localparam int unsigned W  = 8;
  localparam int unsigned EC = 8;
`ifdef COUNTER_RX_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clock, reset, latch, in_a, in_b;
  logic          word_valid, err_a, err_b, frame_err, err_sticky;
  logic [W-1:0]  word_a, word_b;
  logic [EC-1:0] err_count;

  counter_stream_receiver #(.WIDTH(W), .ERR_CNT_W(EC)) dut (
    .clock(clock), .reset(reset), .latch(latch), .in_a(in_a), .in_b(in_b),
    .word_valid(word_valid), .word_a(word_a), .word_b(word_b),
    .err_a(err_a), .err_b(err_b), .frame_err(frame_err),
    .err_sticky(err_sticky), .err_count(err_count)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Expected outputs, valid between one clock edge and the next.
  logic          exp_valid, exp_err_a, exp_err_b, exp_frame_err, exp_sticky;
  logic [W-1:0]  exp_word_a, exp_word_b;
  logic [EC-1:0] exp_count;
  // Frame-level model state.
  logic [W-1:0]  m_prev_a, m_prev_b;
  bit            m_seeded, m_open;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle: all outputs against the model.
  always @(negedge clock) begin
    chk("word_valid", 32'(word_valid), 32'(exp_valid));
    chk("word_a",     32'(word_a),     32'(exp_word_a));
    chk("word_b",     32'(word_b),     32'(exp_word_b));
    chk("err_a",      32'(err_a),      32'(exp_err_a));
    chk("err_b",      32'(err_b),      32'(exp_err_b));
    chk("frame_err",  32'(frame_err),  32'(exp_frame_err));
    chk("err_sticky", 32'(err_sticky), 32'(exp_sticky));
    chk("err_count",  32'(err_count),  32'(exp_count));
  end

  task automatic model_clear();
    exp_valid = 0; exp_err_a = 0; exp_err_b = 0; exp_frame_err = 0;
    exp_sticky = 0; exp_word_a = '0; exp_word_b = '0; exp_count = '0;
    m_prev_a = '0; m_prev_b = '0; m_seeded = 0; m_open = 0;
  endtask

  task automatic count_event();
    if (CHK) begin
      exp_sticky = 1'b1;
      if (exp_count != {EC{1'b1}}) exp_count = exp_count + EC'(1);
    end
  endtask

  // One serial cycle: drive on the falling edge, pulses expire after the rise.
  task automatic step(input logic l, input logic a, input logic b);
    @(negedge clock);
    latch = l; in_a = a; in_b = b;
    @(posedge clock);
    #1;
    exp_valid = 0; exp_frame_err = 0; exp_err_a = 0; exp_err_b = 0;
  endtask

  task automatic first_bit(input logic [W-1:0] a, input logic [W-1:0] b);
    step(1'b1, a[W-1], b[W-1]);
    if (m_open) begin
      exp_frame_err = 1'b1;
      m_seeded = 0;
      count_event();
    end
    m_open = 1;
  endtask

  task automatic send_word(input logic [W-1:0] a, input logic [W-1:0] b);
    bit ea, eb;
    first_bit(a, b);
    for (int i = W - 2; i >= 0; i--) step(1'b0, a[i], b[i]);
    m_open = 0;
    ea = CHK && m_seeded && (a != W'(m_prev_a - 1));
    eb = CHK && m_seeded && (b != W'(m_prev_b + 1));
    exp_valid = 1; exp_word_a = a; exp_word_b = b;
    exp_err_a = ea; exp_err_b = eb;
    if (ea || eb) count_event();
    m_prev_a = a; m_prev_b = b; m_seeded = 1;
  endtask

  task automatic send_partial(input logic [W-1:0] a, input logic [W-1:0] b, input int n);
    first_bit(a, b);
    for (int i = 1; i < n; i++) step(1'b0, a[W-1-i], b[W-1-i]);
  endtask

  // Asynchronous reset pulse, asserted away from any clock edge.
  task automatic hard_reset();
    #2;
    reset = 0; latch = 0;
    #1;
    model_clear();
    chk("rst_word_valid", 32'(word_valid), 0);
    chk("rst_word_a",     32'(word_a),     0);
    chk("rst_word_b",     32'(word_b),     0);
    chk("rst_frame_err",  32'(frame_err),  0);
    chk("rst_sticky",     32'(err_sticky), 0);
    chk("rst_count",      32'(err_count),  0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1;
  endtask

  initial begin
    clock = 0; reset = 0; latch = 0; in_a = 0; in_b = 0;
    model_clear();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1;

    // Basic: two in-sequence words back to back.
    send_word(8'hFF, 8'h81);
    chk("t1_valid", 32'(word_valid), 1);
    chk("t1_word_a", 32'(word_a), 32'h FF);
    send_word(8'hFE, 8'h82);
    chk("t1_word_b", 32'(word_b), 32'h82);
    chk("t1_err_a", 32'(err_a), 0);
    chk("t1_count", 32'(err_count), 0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'($urandom), 1'($urandom));

    // Wrap-around on both lanes.
    hard_reset();
    send_word(8'h00, 8'hFF);
    send_word(8'hFF, 8'h00);
    chk("wrap_err_a", 32'(err_a), 0);
    chk("wrap_err_b", 32'(err_b), 0);
    chk("wrap_valid", 32'(word_valid), 1);

    // One corrupt lane-A word flags on entry and exit.
    hard_reset();
    send_word(8'h10, 8'h20);
    send_word(8'h2F, 8'h21);
    chk("corr_err_a2", 32'(err_a), 32'(CHK));
    send_word(8'h0E, 8'h22);
    chk("corr_err_a3", 32'(err_a), 32'(CHK));
    chk("corr_err_b3", 32'(err_b), 0);
    chk("corr_count", 32'(err_count), CHK ? 2 : 0);
    chk("corr_sticky", 32'(err_sticky), 32'(CHK));

    // Latch mid-word: partial dropped, next word unchecked.
    hard_reset();
    send_word(8'h40, 8'h60);
    send_partial(8'h3F, 8'h61, 4);
    send_word(8'h99, 8'h99);
    chk("frm_word_a", 32'(word_a), 32'h99);
    chk("frm_err_a", 32'(err_a), 0);
    chk("frm_count", 32'(err_count), CHK ? 1 : 0);
    send_word(8'h98, 8'h9A);
    chk("frm_next_err_a", 32'(err_a), 0);
    chk("frm_next_err_b", 32'(err_b), 0);

    // Saturation: every word errors on both lanes.
    hard_reset();
    for (int i = 0; i < 300; i++) send_word(8'h55, 8'h55);
    chk("sat_count", 32'(err_count), CHK ? 255 : 0);
    chk("sat_sticky", 32'(err_sticky), 32'(CHK));

    // Async reset mid-word after errors have accumulated.
    send_word(8'h12, 8'h34);
    send_partial(8'hAB, 8'hCD, 5);
    hard_reset();
    send_word(8'h50, 8'h70);
    chk("post_rst_err_a", 32'(err_a), 0);
    chk("post_rst_word_a", 32'(word_a), 32'h50);
    send_word(8'h4F, 8'h71);
    chk("post_rst_count", 32'(err_count), 0);
    step(1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
